// File: rtl/pixel_raster_gen_pkg.sv
// Shared raster types and geometry for the pixel sequencer and the line-buffer stage.
// Holds the FSM encoding, a width helper and the default frame size.
package pixel_raster_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HBLANK = 2'd2,
      VBLANK = 2'd3
   } rasterState_t;

   localparam int DEF_IMG_W = 8;
   localparam int DEF_IMG_H = 4;

   // Ceiling log2, floored at 1 so that a degenerate range still yields a usable vector width.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return (res < 1) ? 1 : res;
   endfunction

endpackage

// File: rtl/pixel_raster_gen_if.sv
// Raster output bus: enable/start requests in, pixel position and frame markers out.
// The generator drives through the master modport; the line-buffer side uses slave.
interface pixel_raster_gen_if #(
   parameter int COL_W  = 3,
   parameter int ROW_W  = 2,
   parameter int ADDR_W = 5
);
   logic              iEnable;
   logic              iStart;
   logic              oValid;
   logic [ADDR_W-1:0] oAddr;
   logic [COL_W-1:0]  oCol;
   logic [ROW_W-1:0]  oRow;
   logic              oSof;
   logic              oEol;
   logic              oEof;
   logic              oBusy;

   modport master (
      input  iEnable, iStart,
      output oValid, oAddr, oCol, oRow, oSof, oEol, oEof, oBusy
   );

   modport slave (
      output iEnable, iStart,
      input  oValid, oAddr, oCol, oRow, oSof, oEol, oEof, oBusy
   );
endinterface

// File: rtl/pixel_raster_gen_raster_counter.sv
// Row-major col/row/addr counters with last-column/last-row flags; steps one position per iAdvance.
// Latency: one clock from iAdvance to new position; iClear has priority and returns to (0,0).
module raster_counter #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 4,
   parameter int COL_W  = 3,
   parameter int ROW_W  = 2,
   parameter int ADDR_W = 5
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iClear,
   input  logic              iAdvance,
   output logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  row,
   output logic [ADDR_W-1:0] addr,
   output logic              lastCol,
   output logic              lastRow
);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   assign lastCol = (col == COL_LAST);
   assign lastRow = (row == ROW_LAST);

   // addr tracks row*IMG_W+col incrementally and wraps to 0 after the final pixel.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (iClear) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (iAdvance) begin
         if (lastCol) begin
            col <= '0;
            if (lastRow) begin
               row  <= '0;
               addr <= '0;
            end else begin
               row  <= row + 1'b1;
               addr <= addr + 1'b1;
            end
         end else begin
            col  <= col + 1'b1;
            addr <= addr + 1'b1;
         end
      end
   end
endmodule

// File: rtl/pixel_raster_gen.sv
// Raster sequencer: one pixel position per enable tick with H/V blanking; outputs one clock after the enable edge.
// No backpressure: iEnable paces everything, iEnable=0 freezes state, iStart is taken only in IDLE.
module pixel_raster_gen
   import pixel_raster_gen_pkg::*;
#(
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int H_BLANK    = 2,
   parameter int V_BLANK    = 3,
   parameter int CONTINUOUS = 0
) (
   input logic iClk,
   input logic iRst,
   pixel_raster_gen_if.master bus
);
   localparam int COL_W  = clog2(IMG_W);
   localparam int ROW_W  = clog2(IMG_H);
   localparam int ADDR_W = clog2(IMG_W * IMG_H);
   localparam int BLK_W  = clog2(((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK) + 1);

   localparam logic [BLK_W-1:0] H_LOAD  = BLK_W'(H_BLANK);
   localparam logic [BLK_W-1:0] V_LOAD  = BLK_W'(V_BLANK);
   localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);

   rasterState_t      state, stateNext;
   logic [BLK_W-1:0]  blankCnt, blankNext;
   logic              advance, clear, present;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] addr;
   logic              lastCol, lastRow;

   logic              validQ, sofQ, eolQ, eofQ, busyQ;
   logic [ADDR_W-1:0] addrQ;
   logic [COL_W-1:0]  colQ;
   logic [ROW_W-1:0]  rowQ;

   raster_counter #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
   ) uCounter (
      .iClk(iClk), .iRst(iRst), .iClear(clear), .iAdvance(advance),
      .col(col), .row(row), .addr(addr), .lastCol(lastCol), .lastRow(lastRow)
   );

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state    <= IDLE;
         blankCnt <= '0;
      end else begin
         state    <= stateNext;
         blankCnt <= blankNext;
      end
   end

   always_comb begin
      stateNext = state;
      blankNext = blankCnt;
      advance   = 1'b0;
      clear     = 1'b0;
      present   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iStart) begin
               stateNext = ACTIVE;
               clear     = 1'b1;
            end
         end
         ACTIVE: begin
            if (bus.iEnable) begin
               present = 1'b1;
               advance = 1'b1;
               if (lastCol && lastRow) begin
                  if (V_BLANK > 0) begin
                     stateNext = VBLANK;
                     blankNext = V_LOAD;
                  end else begin
                     stateNext = (CONTINUOUS != 0) ? ACTIVE : IDLE;
                  end
               end else if (lastCol && (H_BLANK > 0)) begin
                  stateNext = HBLANK;
                  blankNext = H_LOAD;
               end
            end
         end
         HBLANK: begin
            if (bus.iEnable) begin
               blankNext = blankCnt - 1'b1;
               if (blankCnt == BLK_ONE) stateNext = ACTIVE;
            end
         end
         VBLANK: begin
            if (bus.iEnable) begin
               blankNext = blankCnt - 1'b1;
               if (blankCnt == BLK_ONE) begin
                  stateNext = (CONTINUOUS != 0) ? ACTIVE : IDLE;
                  clear     = 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Markers pulse for one clock; position holds its last presented value between pulses.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         validQ <= 1'b0;
         sofQ   <= 1'b0;
         eolQ   <= 1'b0;
         eofQ   <= 1'b0;
         busyQ  <= 1'b0;
         addrQ  <= '0;
         colQ   <= '0;
         rowQ   <= '0;
      end else begin
         validQ <= present;
         sofQ   <= present && (col == '0) && (row == '0);
         eolQ   <= present && lastCol;
         eofQ   <= present && lastCol && lastRow;
         busyQ  <= (stateNext != IDLE);
         if (present) begin
            addrQ <= addr;
            colQ  <= col;
            rowQ  <= row;
         end
      end
   end

   assign bus.oValid = validQ;
   assign bus.oAddr  = addrQ;
   assign bus.oCol   = colQ;
   assign bus.oRow   = rowQ;
   assign bus.oSof   = sofQ;
   assign bus.oEol   = eolQ;
   assign bus.oEof   = eofQ;
   assign bus.oBusy  = busyQ;
endmodule

// File: tb/tb_pixel_raster_gen.sv
// Directed bench: 8x4 frame with blanking on dutA, continuous no-hblank frames on dutB.
module tb_pixel_raster_gen;
   import pixel_raster_gen_pkg::*;

   typedef struct {
      int addr; int col; int row; int sof; int eol; int eof; int tick; int cyc;
   } rec_t;

   logic iClk = 1'b0;
   logic iRst;
   logic iEnable;
   logic startA, startB;

   int nChecks = 0;
   int nPass   = 0;
   int tickNo  = 0;
   int cyc     = 0;
   bit monB    = 1'b0;
   int busyDrops = 0;
   rec_t qA[$];
   rec_t qB[$];

   pixel_raster_gen_if #(.COL_W(3), .ROW_W(2), .ADDR_W(5)) ifA ();
   pixel_raster_gen_if #(.COL_W(3), .ROW_W(2), .ADDR_W(5)) ifB ();

   assign ifA.iEnable = iEnable;
   assign ifB.iEnable = iEnable;
   assign ifA.iStart  = startA;
   assign ifB.iStart  = startB;

   pixel_raster_gen #(.IMG_W(8), .IMG_H(4), .H_BLANK(2), .V_BLANK(3), .CONTINUOUS(0))
      dutA (.iClk(iClk), .iRst(iRst), .bus(ifA.master));
   pixel_raster_gen #(.IMG_W(8), .IMG_H(4), .H_BLANK(0), .V_BLANK(3), .CONTINUOUS(1))
      dutB (.iClk(iClk), .iRst(iRst), .bus(ifB.master));

   always #5 iClk = ~iClk;

   always @(posedge iClk) cyc++;

   always @(negedge iClk) begin
      if (ifA.oValid)
         qA.push_back('{int'(ifA.oAddr), int'(ifA.oCol), int'(ifA.oRow), int'(ifA.oSof),
                        int'(ifA.oEol), int'(ifA.oEof), tickNo, cyc});
      if (ifB.oValid)
         qB.push_back('{int'(ifB.oAddr), int'(ifB.oCol), int'(ifB.oRow), int'(ifB.oSof),
                        int'(ifB.oEol), int'(ifB.oEof), tickNo, cyc});
      if (monB && !ifB.oBusy) busyDrops++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   // One 1-in-8 enable period: a single enable clock followed by seven quiet clocks.
   task automatic enTick();
      tickNo++;
      iEnable = 1'b1;
      step();
      iEnable = 1'b0;
      repeat (7) step();
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, " oValid"}, int'(ifA.oValid), 0);
      check({tag, " oAddr"},  int'(ifA.oAddr),  0);
      check({tag, " oCol"},   int'(ifA.oCol),   0);
      check({tag, " oRow"},   int'(ifA.oRow),   0);
      check({tag, " oSof"},   int'(ifA.oSof),   0);
      check({tag, " oEol"},   int'(ifA.oEol),   0);
      check({tag, " oEof"},   int'(ifA.oEof),   0);
      check({tag, " oBusy"},  int'(ifA.oBusy),  0);
   endtask

   initial begin
      int ticks;
      int sofCount;
      iRst = 1'b0; iEnable = 1'b0; startA = 1'b0; startB = 1'b0;
      repeat (3) step();
      checkAllZero("reset");
      check("reset busyB", int'(ifB.oBusy), 0);
      iRst = 1'b1;
      step();

      // Full frame with a stray start pulse mid-frame.
      startA = 1'b1; step(); startA = 1'b0;
      check("start busy", int'(ifA.oBusy), 1);
      check("start no pixel", qA.size(), 0);
      tickNo = 0;
      ticks  = 0;
      while (ifA.oBusy && ticks < 60) begin
         enTick();
         ticks++;
         if (ticks == 10) begin
            startA = 1'b1; step(); startA = 1'b0;
         end
      end
      check("frame ticks", ticks, 41);
      check("frame pixels", qA.size(), 32);
      for (int i = 0; i < 32 && i < qA.size(); i++) begin
         check($sformatf("A addr[%0d]", i), qA[i].addr, i);
         check($sformatf("A col[%0d]", i),  qA[i].col,  i % 8);
         check($sformatf("A row[%0d]", i),  qA[i].row,  i / 8);
         check($sformatf("A sof[%0d]", i),  qA[i].sof,  (i == 0) ? 1 : 0);
         check($sformatf("A eol[%0d]", i),  qA[i].eol,  (i % 8 == 7) ? 1 : 0);
         check($sformatf("A eof[%0d]", i),  qA[i].eof,  (i == 31) ? 1 : 0);
         check($sformatf("A tick[%0d]", i), qA[i].tick, i + (i / 8) * 2 + 1);
         if (i % 8 != 0)
            check($sformatf("A spacing[%0d]", i), qA[i].cyc - qA[i-1].cyc, 8);
      end
      repeat (3) enTick();
      check("post-frame idle busy", int'(ifA.oBusy), 0);
      check("post-frame no pixels", qA.size(), 32);

      // Start coincident with enable: no pixel on that edge.
      qA.delete();
      tickNo = 0;
      startA = 1'b1; iEnable = 1'b1; step();
      startA = 1'b0; iEnable = 1'b0;
      repeat (7) step();
      check("coincident no pixel", qA.size(), 0);
      check("coincident busy", int'(ifA.oBusy), 1);
      enTick();
      check("coincident first count", qA.size(), 1);
      if (qA.size() >= 1) begin
         check("coincident first addr", qA[0].addr, 0);
         check("coincident first sof", qA[0].sof, 1);
         check("coincident first tick", qA[0].tick, 1);
      end

      // Enable held low mid-line.
      repeat (3) enTick();
      check("gate pre count", qA.size(), 4);
      check("gate pre addr", int'(ifA.oAddr), 3);
      repeat (50) step();
      check("gate hold count", qA.size(), 4);
      check("gate hold addr", int'(ifA.oAddr), 3);
      check("gate hold valid", int'(ifA.oValid), 0);
      check("gate hold busy", int'(ifA.oBusy), 1);
      enTick();
      check("gate resume count", qA.size(), 5);
      if (qA.size() >= 5) check("gate resume addr", qA[4].addr, 4);

      // Asynchronous reset after five pixels.
      iRst = 1'b0;
      #1;
      checkAllZero("midreset");
      step(); step();
      iRst = 1'b1;
      step();
      repeat (3) enTick();
      check("after reset no pixels", qA.size(), 5);
      check("after reset busy", int'(ifA.oBusy), 0);
      startA = 1'b1; step(); startA = 1'b0;
      enTick();
      check("restart count", qA.size(), 6);
      if (qA.size() >= 6) begin
         check("restart addr", qA[5].addr, 0);
         check("restart sof", qA[5].sof, 1);
      end

      // Continuous mode, no horizontal blanking: two full frames.
      qB.delete();
      tickNo = 0;
      startB = 1'b1; step(); startB = 1'b0;
      monB = 1'b1;
      repeat (70) enTick();
      monB = 1'b0;
      check("B pixels", qB.size(), 64);
      check("B busy drops", busyDrops, 0);
      sofCount = 0;
      for (int i = 0; i < 64 && i < qB.size(); i++) begin
         sofCount += qB[i].sof;
         check($sformatf("B addr[%0d]", i), qB[i].addr, i % 32);
         check($sformatf("B tick[%0d]", i), qB[i].tick, (i / 32) * 35 + (i % 32) + 1);
         check($sformatf("B eol[%0d]", i),  qB[i].eol,  (i % 8 == 7) ? 1 : 0);
         check($sformatf("B eof[%0d]", i),  qB[i].eof,  (i % 32 == 31) ? 1 : 0);
      end
      check("B sof count", sofCount, 2);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule

// File: doc/pixel_raster_gen.md
Name: pixel_raster_gen

Overview:
- Raster pixel sequencer that consumes the 1-in-N clock-enable strobe and walks an IMG_W x IMG_H frame in row-major order.
- Advances one pixel position per enable tick.
- Emits a linear frame-memory read address, column/row coordinates and frame/line markers, which feed the line-buffer stage.
- Inserts programmable horizontal and vertical blanking, counted in enable ticks.

Parameters:
- IMG_W, 8, active pixels per line (>=2).
- IMG_H, 4, active lines per frame (>=2).
- H_BLANK, 2, enable ticks of blanking after each line (0 = none).
- V_BLANK, 3, enable ticks of blanking after the last line (0 = none).
- CONTINUOUS, 0, 1 = restart a new frame automatically after V_BLANK.

Derived localparams (not overridable):
- COL_W = clog2(IMG_W)
- ROW_W = clog2(IMG_H)
- ADDR_W = clog2(IMG_W*IMG_H)
- BLK_W = clog2(max(H_BLANK,V_BLANK)+1)

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous active-low reset.
- iEnable  in  1  one-cycle advance strobe from the clock-enable divider.
- iStart  in  1  frame start request; honoured only in IDLE.
- oValid  out  1  one-clock pulse; coordinates/address valid this cycle.
- oAddr  out  ADDR_W  row*IMG_W+col of the presented pixel.
- oCol  out  COL_W  column of the presented pixel.
- oRow  out  ROW_W  row of the presented pixel.
- oSof  out  1  with oValid, first pixel of frame (0,0).
- oEol  out  1  with oValid, last pixel of a line.
- oEof  out  1  with oValid, last pixel of frame.
- oBusy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, iRst=0): state IDLE; all outputs 0; internal col/row/addr/blank counters 0. Takes effect immediately, including mid-frame; no partial frame resumes after release.
- All outputs are registered. oValid, oSof, oEol and oEof are high for exactly one clock, on the cycle after an edge that sampled iEnable=1 in ACTIVE. They are 0 on all other cycles.
- oAddr, oCol and oRow hold their last presented value between pulses.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - iStart=1 at any edge, regardless of iEnable, moves to ACTIVE with col=row=addr=0.
  - No pixel is emitted on that edge.
- ACTIVE, on each edge with iEnable=1:
  - Present current (col,row,addr) and pulse oValid.
  - oSof=1 if col=0 and row=0.
  - oEol=1 if col=IMG_W-1.
  - oEof=1 if col=IMG_W-1 and row=IMG_H-1.
  - Then advance: col+1 and addr+1. At col=IMG_W-1: col wraps to 0, row+1, addr+1.
- End of line: after presenting col=IMG_W-1 with row<IMG_H-1:
  - H_BLANK>0: go to HBLANK with the blank counter loaded to H_BLANK.
  - H_BLANK=0: stay in ACTIVE; the next tick presents the next line.
- End of frame: after presenting the last pixel:
  - V_BLANK>0: go to VBLANK with the counter loaded to V_BLANK.
  - V_BLANK=0: exit directly as described under VBLANK expiry.
- HBLANK/VBLANK: each iEnable=1 edge decrements the counter. On the edge that reaches 0:
  - HBLANK goes to ACTIVE.
  - VBLANK goes to IDLE, or to ACTIVE with counters cleared if CONTINUOUS=1.
- Blanking is counted only on enable ticks, never on plain clocks.
- iEnable=0 freezes all state and counters except the IDLE->ACTIVE start transition.
- iStart outside IDLE is ignored and not queued.
- iStart and iEnable high on the same IDLE edge: start only; the first pixel is presented on the next enable tick.
- Latency: first oValid occurs one clock after the first enable edge following start acceptance.
- Throughput: at most one pixel per enable tick.
- Frame length: IMG_W*IMG_H + (IMG_H-1)*H_BLANK + V_BLANK enable ticks.
- Address never exceeds IMG_W*IMG_H-1. Arithmetic is unsigned, and addr is an incremental counter (no multiplier).

Decomposition:
- Shared package holds:
  - state encoding typedef/localparams (IDLE=0, ACTIVE=1, HBLANK=2, VBLANK=3);
  - a clog2 helper function;
  - default image geometry constants, shared with the line-buffer stage.
- One natural sub-module, raster_counter: col/row/addr counters with wrap and last-flags, driven by an advance input. The FSM and blanking counter stay in the top.

Test Plan:
- Reset mid-frame:
  - Stimulus: start, let 5 pixels emit, pull iRst low for 2 clocks, release.
  - Required: all outputs 0 immediately; oBusy=0; no oValid until a new iStart.
- Full frame, defaults:
  - Stimulus: iEnable from the 1-in-8 divider, iStart pulse.
  - Required: exactly 32 oValid pulses, each 8 clocks apart within a line; oAddr 0..31 in order; oSof only at addr 0; oEol at addr 7, 15, 23, 31; oEof only at addr 31.
- Blanking:
  - Required: 2 idle enable ticks (no oValid) between addr 7 and addr 8; 3 ticks after addr 31 before oBusy falls.
  - Required: total frame time 32+3*2+3=41 enable ticks.
- Start edge cases:
  - Stimulus: iStart coincident with iEnable in IDLE.
  - Required: the first oValid (addr 0) arrives on the following enable tick.
  - Stimulus: iStart pulsed while busy.
  - Required: no effect; the frame still ends at addr 31.
- Enable gating:
  - Stimulus: hold iEnable=0 for 50 clocks mid-line (e.g. after addr 3).
  - Required: no oValid; oAddr holds at 3; the next tick resumes at addr 4.
- CONTINUOUS=1, H_BLANK=0:
  - Required: 64 consecutive-tick pixels across two frames with 3-tick gaps only after each addr 31; oSof twice; oBusy never drops.
